audio_source_arbiter: RTL and testbench

Shares the single audio output path (volume scaler feeding the PWM stage) between NUM_SRC sample producers, such as tone generator, playback buffer and mic loopback.
- Generates the audio sample-rate strobe from the 98.3 MHz audio clock.
- Grants exactly one source per sample period using fixed priority, lowest index wins.
- Registers that source's 8-bit signed sample.
- Drives the 3-bit volume code so that ownership changes are click-free fade-out/fade-in ramps.

---
 rtl/audio_source_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_audio_source_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/audio_source_arbiter.sv
// Sample-rate arbiter that hands the single audio output path to one of NUM_SRC producers.
// Define AUDIO_ARB_FADE_EN to get click-free fade-out/fade-in ramps on ownership changes.
module audio_source_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int SAMPLE_DIV = 8192,
  parameter int CNT_W      = $clog2(SAMPLE_DIV)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [NUM_SRC-1:0]   req_in,
  input  logic [8*NUM_SRC-1:0] sample_in,
  output logic [NUM_SRC-1:0]   sample_ack_out,
  output logic [NUM_SRC-1:0]   grant_out,
  output logic [7:0]           sample_out,
  output logic [2:0]           vol_out,
  output logic                 sample_valid_out
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_PLAY     = 2'd2,
    ST_FADE_OUT = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 tick_s;
  logic [NUM_SRC-1:0]   grant_r, grant_s;
  logic [2:0]           vol_r, vol_s;
  logic [7:0]           sample_r;
  logic [NUM_SRC-1:0]   ack_r;
  logic                 valid_r;
  logic                 any_req_s;
  logic [NUM_SRC-1:0]   winner_s;
  logic                 exit_s;
  logic [7:0]           owner_sample_s;

  assign tick_s    = (cnt_r == CNT_W'(SAMPLE_DIV - 1));
  assign any_req_s = |req_in;
  // Isolates the lowest set request bit: lowest index wins.
  assign winner_s  = req_in & (~req_in + NUM_SRC'(1));
  // Owner loses the path when it drops its request or any lower index asks.
  assign exit_s    = ((req_in & grant_r) == '0) || ((req_in & (grant_r - NUM_SRC'(1))) != '0);

  // Sample-period counter producing the one-cycle tick.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Selects the current owner's sample from the packed sample bus.
  always_comb begin
    owner_sample_s = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_r[i]) begin
        owner_sample_s = owner_sample_s | sample_in[8*i +: 8];
      end else begin
        owner_sample_s = owner_sample_s;
      end
    end
  end

  // Next-state, grant and volume decisions, applied only on a tick.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    vol_s   = vol_r;
    if (tick_s) begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant_s = winner_s;
`ifdef AUDIO_ARB_FADE_EN
            vol_s   = 3'd0;
            state_s = ST_FADE_IN;
`else
            vol_s   = 3'd7;
            state_s = ST_PLAY;
`endif
          end else begin
            grant_s = '0;
            vol_s   = 3'd0;
          end
        end
`ifdef AUDIO_ARB_FADE_EN
        ST_FADE_IN: begin
          if (exit_s) begin
            state_s = ST_FADE_OUT;
          end else begin
            vol_s = vol_r + 3'd1;
            if (vol_r == 3'd6) begin
              state_s = ST_PLAY;
            end else begin
              state_s = ST_FADE_IN;
            end
          end
        end
        ST_PLAY: begin
          vol_s = 3'd7;
          if (exit_s) begin
            state_s = ST_FADE_OUT;
          end else begin
            state_s = ST_PLAY;
          end
        end
        ST_FADE_OUT: begin
          // The ramp always completes before ownership is re-decided.
          if (vol_r != 3'd0) begin
            vol_s = vol_r - 3'd1;
          end else if (any_req_s) begin
            grant_s = winner_s;
            state_s = ST_FADE_IN;
          end else begin
            grant_s = '0;
            state_s = ST_IDLE;
          end
        end
`else
        ST_PLAY: begin
          if (exit_s && any_req_s) begin
            grant_s = winner_s;
            vol_s   = 3'd7;
          end else if (exit_s) begin
            grant_s = '0;
            vol_s   = 3'd0;
            state_s = ST_IDLE;
          end else begin
            vol_s = 3'd7;
          end
        end
`endif
        default: begin
          state_s = ST_IDLE;
          grant_s = '0;
          vol_s   = 3'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state, grant and volume registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      vol_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      vol_r   <= vol_s;
    end
  end

  // Capture from the pre-update owner; idle ticks still emit a zero sample.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sample_r <= 8'h00;
      ack_r    <= '0;
      valid_r  <= 1'b0;
    end else if (tick_s) begin
      valid_r <= 1'b1;
      if (grant_r != '0) begin
        sample_r <= owner_sample_s;
        ack_r    <= grant_r;
      end else begin
        sample_r <= 8'h00;
        ack_r    <= '0;
      end
    end else begin
      valid_r <= 1'b0;
      ack_r   <= '0;
    end
  end

  assign grant_out        = grant_r;
  assign vol_out          = vol_r;
  assign sample_out       = sample_r;
  assign sample_ack_out   = ack_r;
  assign sample_valid_out = valid_r;

endmodule

// File: tb/tb_audio_source_arbiter.sv
// Table-driven bench for audio_source_arbiter (NUM_SRC=3, SAMPLE_DIV=16), one row per tick.
module tb_audio_source_arbiter;

  localparam int NS = 3;
  localparam int SD = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [NS-1:0] req_in = '0;
  logic [8*NS-1:0] sample_in;
  logic [NS-1:0] sample_ack_out, grant_out;
  logic [7:0]    sample_out;
  logic [2:0]    vol_out;
  logic          sample_valid_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] req;
    logic [2:0] g;
    logic [2:0] v;
    logic [7:0] s;
    logic [2:0] ack;
    logic [2:0] greq;
    int         glen;
  } vec_t;

  vec_t vecs[$];

  audio_source_arbiter #(.NUM_SRC(NS), .SAMPLE_DIV(SD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .sample_in(sample_in),
    .sample_ack_out(sample_ack_out), .grant_out(grant_out), .sample_out(sample_out),
    .vol_out(vol_out), .sample_valid_out(sample_valid_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic vec_t mk(logic [2:0] req, logic [2:0] g, logic [2:0] v, logic [7:0] s,
                              logic [2:0] ack, logic [2:0] greq = 3'b000, int glen = 0);
    vec_t r;
    r.req = req; r.g = g; r.v = v; r.s = s; r.ack = ack; r.greq = greq; r.glen = glen;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Holds glitch request for the first glen cycles, then base; returns cycles to next valid.
  task automatic run_tick(input logic [2:0] base, input logic [2:0] greq, input int glen,
                          output int n);
    n = 0;
    req_in = (glen > 0) ? greq : base;
    do begin
      @(negedge clk_in);
      n++;
      req_in = (n < glen) ? greq : base;
    end while (!sample_valid_out && n < 4 * SD);
  endtask

  task automatic apply(input vec_t v, input int idx);
    int n;
    string tag;
    run_tick(v.req, v.greq, v.glen, n);
    tag = $sformatf("row%0d", idx);
    check({tag, ".period"}, n, SD);
    check({tag, ".grant"}, grant_out, v.g);
    check({tag, ".vol"}, vol_out, v.v);
    check({tag, ".sample"}, sample_out, v.s);
    check({tag, ".ack"}, sample_ack_out, v.ack);
  endtask

  initial begin
    int n;
    sample_in = {8'h11, 8'h40, 8'hFB};

`ifdef AUDIO_ARB_FADE_EN
    vecs.push_back(mk(3'b000, 3'b000, 3'd0, 8'h00, 3'b000));
    vecs.push_back(mk(3'b010, 3'b010, 3'd0, 8'h00, 3'b000));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(3'b010, 3'b010, 3'(k), 8'h40, 3'b010));
    vecs.push_back(mk(3'b010, 3'b010, 3'd7, 8'h40, 3'b010));
    vecs.push_back(mk(3'b011, 3'b010, 3'd7, 8'h40, 3'b010));
    for (int k = 6; k >= 0; k--) vecs.push_back(mk(3'b011, 3'b010, 3'(k), 8'h40, 3'b010));
    vecs.push_back(mk(3'b011, 3'b001, 3'd0, 8'h40, 3'b010));
    vecs.push_back(mk(3'b011, 3'b001, 3'd1, 8'hFB, 3'b001));
    for (int k = 2; k <= 7; k++) vecs.push_back(mk(3'b001, 3'b001, 3'(k), 8'hFB, 3'b001));
    vecs.push_back(mk(3'b000, 3'b001, 3'd7, 8'hFB, 3'b001));
    for (int k = 6; k >= 0; k--) vecs.push_back(mk(3'b000, 3'b001, 3'(k), 8'hFB, 3'b001));
    vecs.push_back(mk(3'b000, 3'b000, 3'd0, 8'hFB, 3'b001));
    vecs.push_back(mk(3'b000, 3'b000, 3'd0, 8'h00, 3'b000));
    vecs.push_back(mk(3'b000, 3'b000, 3'd0, 8'h00, 3'b000, 3'b001, 5));
    vecs.push_back(mk(3'b010, 3'b010, 3'd0, 8'h00, 3'b000));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(3'b010, 3'b010, 3'(k), 8'h40, 3'b010));
    vecs.push_back(mk(3'b000, 3'b010, 3'd7, 8'h40, 3'b010));
    for (int k = 6; k >= 4; k--) vecs.push_back(mk(3'b000, 3'b010, 3'(k), 8'h40, 3'b010));
`else
    vecs.push_back(mk(3'b000, 3'b000, 3'd0, 8'h00, 3'b000));
    vecs.push_back(mk(3'b000, 3'b000, 3'd0, 8'h00, 3'b000));
    vecs.push_back(mk(3'b010, 3'b010, 3'd7, 8'h00, 3'b000));
    vecs.push_back(mk(3'b010, 3'b010, 3'd7, 8'h40, 3'b010));
    vecs.push_back(mk(3'b011, 3'b001, 3'd7, 8'h40, 3'b010));
    vecs.push_back(mk(3'b011, 3'b001, 3'd7, 8'hFB, 3'b001));
    vecs.push_back(mk(3'b111, 3'b001, 3'd7, 8'hFB, 3'b001));
    vecs.push_back(mk(3'b110, 3'b010, 3'd7, 8'hFB, 3'b001));
    vecs.push_back(mk(3'b100, 3'b100, 3'd7, 8'h40, 3'b010));
    vecs.push_back(mk(3'b100, 3'b100, 3'd7, 8'h11, 3'b100));
    vecs.push_back(mk(3'b000, 3'b000, 3'd0, 8'h11, 3'b100));
    vecs.push_back(mk(3'b000, 3'b000, 3'd0, 8'h00, 3'b000));
    vecs.push_back(mk(3'b000, 3'b000, 3'd0, 8'h00, 3'b000, 3'b001, 5));
    vecs.push_back(mk(3'b010, 3'b010, 3'd7, 8'h00, 3'b000));
    vecs.push_back(mk(3'b010, 3'b010, 3'd7, 8'h40, 3'b010));
`endif

    // Reset state while held.
    repeat (3) @(negedge clk_in);
    check("rst.grant", grant_out, 3'b000);
    check("rst.vol", vol_out, 3'd0);
    check("rst.sample", sample_out, 8'h00);
    check("rst.valid", sample_valid_out, 1'b0);
    rst_in = 1'b0;

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset in the middle of a sample period, between clock edges.
    repeat (3) @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("async.grant", grant_out, 3'b000);
    check("async.vol", vol_out, 3'd0);
    check("async.sample", sample_out, 8'h00);
    check("async.ack", sample_ack_out, 3'b000);
    @(negedge clk_in);
    rst_in = 1'b0;
    run_tick(3'b010, 3'b000, 0, n);
    check("post_rst.period", n, SD);
    check("post_rst.grant", grant_out, 3'b010);
`ifdef AUDIO_ARB_FADE_EN
    check("post_rst.vol", vol_out, 3'd0);
`else
    check("post_rst.vol", vol_out, 3'd7);
`endif
    check("post_rst.sample", sample_out, 8'h00);
    check("post_rst.ack", sample_ack_out, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
